// File: rtl/playlist_mcu.sv
// rtl/playlist_mcu.sv - playlist sequencer driving play/song/reset_player for song_reader
// Optional: PLAYLIST_MCU_REPEAT_EN adds repeat_mode (replay current song on song_done).
module playlist_mcu #(
  parameter int NUM_SONGS    = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       prev_button,
  input  logic       song_done,
`ifdef PLAYLIST_MCU_REPEAT_EN
  input  logic       repeat_mode,
`endif
  output logic       play,
  output logic       reset_player,
  output logic [1:0] song
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    PAUSED   = 2'd1,
    PLAYING  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST  = 4'(RESET_CYCLES - 1);
  localparam logic [1:0] SONG_LAST = 2'(NUM_SONGS - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       resume;
  logic [1:0] next_song;
  logic [1:0] prev_song;
  logic       repeat_on;

  // Explicit wrap at SONG_LAST so NUM_SONGS<4 never walks through unused indices.
  assign next_song = (song == SONG_LAST) ? 2'd0 : song + 2'd1;
  assign prev_song = (song == 2'd0) ? SONG_LAST : song - 2'd1;

`ifdef PLAYLIST_MCU_REPEAT_EN
  assign repeat_on = repeat_mode;
`else
  assign repeat_on = 1'b0;
`endif

  // play/reset_player are registered alongside state so they always match it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_HOLD;
      cnt          <= 4'd0;
      resume       <= 1'b0;
      song         <= 2'd0;
      play         <= 1'b0;
      reset_player <= 1'b1;
    end else begin
      case (state)
        RST_HOLD: begin
          if (cnt == CNT_LAST) begin
            cnt          <= 4'd0;
            reset_player <= 1'b0;
            if (resume) begin
              state <= PLAYING;
              play  <= 1'b1;
            end else begin
              state <= PAUSED;
              play  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        PAUSED: begin
          if (next_button || prev_button) begin
            song         <= next_button ? next_song : prev_song;
            resume       <= 1'b0;
            state        <= RST_HOLD;
            reset_player <= 1'b1;
            play         <= 1'b0;
          end else if (play_button) begin
            state <= PLAYING;
            play  <= 1'b1;
          end
        end

        PLAYING: begin
          if (next_button || prev_button) begin
            song         <= next_button ? next_song : prev_song;
            resume       <= 1'b1;
            state        <= RST_HOLD;
            reset_player <= 1'b1;
            play         <= 1'b0;
          end else if (song_done) begin
            if (repeat_on) begin
              resume <= 1'b1;
            end else if (song == SONG_LAST) begin
              song   <= 2'd0;
              resume <= 1'b0;
            end else begin
              song   <= song + 2'd1;
              resume <= 1'b1;
            end
            state        <= RST_HOLD;
            reset_player <= 1'b1;
            play         <= 1'b0;
          end else if (play_button) begin
            state <= PAUSED;
            play  <= 1'b0;
          end
        end

        default: begin
          state        <= RST_HOLD;
          cnt          <= 4'd0;
          resume       <= 1'b0;
          reset_player <= 1'b1;
          play         <= 1'b0;
        end
      endcase
    end
  end

endmodule
